// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: sequences each instruction through
// 3-5 states and drives every datapath select/enable from the current state.
module multicycle_control #(
  parameter logic [5:0] GPIO_OPCODE = 6'b011111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCen,
  output logic       IorD,
  output logic       Ori,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    BNE    = 4'd9,
    IMMEX  = 4'd10,
    IMMWB  = 4'd11,
    JUMP   = 4'd12,
    JAL    = 4'd13,
    JR     = 4'd14,
    INEX   = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       ori;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_control;
    logic [3:0] state;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_JUMP       = 2'b10;
  localparam logic [1:0] PC_REG_A      = 2'b11;

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // Dispatch after DECODE. Standard opcodes win over the custom IN opcode should they collide.
  function automatic state_e decode_next(input logic [5:0] o, input logic [5:0] f);
    state_e nxt;
    nxt = FETCH;
    case (o)
      OP_LW, OP_SW: nxt = MEMADR;
      OP_RTYPE: begin
        case (f)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: nxt = REX;
          F_JR:                             nxt = JR;
          default:                          nxt = FETCH;
        endcase
      end
      OP_BEQ:                             nxt = BEQ;
      OP_BNE:                             nxt = BNE;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  nxt = IMMEX;
      OP_J:                               nxt = JUMP;
      OP_JAL:                             nxt = JAL;
      default: nxt = (o == GPIO_OPCODE) ? INEX : FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] rex_alu(input logic [5:0] f);
    logic [2:0] alu;
    case (f)
      F_SUB:   alu = ALU_SUB;
      F_AND:   alu = ALU_AND;
      F_OR:    alu = ALU_OR;
      F_SLT:   alu = ALU_SLT;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    logic [2:0] alu;
    case (o)
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      OP_SLTI: alu = ALU_SLT;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl       = '0;
    ctrl.state = state_q;
    state_d    = state_q;

    case (state_q)
      FETCH: begin
        ctrl.i_or_d      = 1'b0;
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src_a   = 1'b0;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_control = ALU_ADD;
        ctrl.pc_src      = PC_ALU_RESULT;
        ctrl.pc_en       = 1'b1;
        state_d          = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_a   = 1'b0;
        ctrl.alu_src_b   = SRCB_BR;
        ctrl.alu_control = ALU_ADD;
        state_d          = decode_next(op, funct);
      end
      MEMADR: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        state_d          = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.i_or_d = 1'b1;
        state_d     = MEMWB;
      end
      MEMWB: begin
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_d         = FETCH;
      end
      MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        state_d        = FETCH;
      end
      REX: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = rex_alu(funct);
        state_d          = RWB;
      end
      RWB: begin
        ctrl.reg_dst    = 2'b01;
        ctrl.mem_to_reg = 2'b00;
        ctrl.reg_write  = 1'b1;
        state_d         = FETCH;
      end
      BEQ, BNE: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_src      = PC_ALU_OUT;
        // The one Mealy-like term: branch outcome follows the live ALU zero flag.
        ctrl.pc_en       = (state_q == BEQ) ? zero : ~zero;
        state_d          = FETCH;
      end
      IMMEX: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = imm_alu(op);
        state_d          = IMMWB;
      end
      IMMWB: begin
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b00;
        ctrl.reg_write  = 1'b1;
        state_d         = FETCH;
      end
      JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value written to $31.
        ctrl.pc_src     = PC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
        state_d         = FETCH;
      end
      JR: begin
        ctrl.pc_src = PC_REG_A;
        ctrl.pc_en  = 1'b1;
        state_d     = FETCH;
      end
      INEX: begin
        ctrl.ori         = 1'b1;
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_OR;
        state_d          = IMMWB;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Asserted reset silences every strobe immediately, aborting any instruction in flight.
    if (!reset) begin
      ctrl = '0;
    end
  end

  assign PCen       = ctrl.pc_en;
  assign IorD       = ctrl.i_or_d;
  assign Ori        = ctrl.ori;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign ALUControl = ctrl.alu_control;
  assign state_o    = ctrl.state;

endmodule
